mac_tx_framer: RTL and testbench

//  Ethernet TX frame sequencer that owns and drives the 16-bit CRC-32 (FCS) engine.

---
 rtl/mac_tx_framer.sv | 189 ++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_framer.sv
// mac_tx_framer
//   Ethernet TX frame sequencer. Pulls 16-bit payload words from an upstream
//   source and emits preamble/SFD, payload, optional zero pad and the FCS
//   produced by an external 16-bit CRC-32 engine, then holds the line idle
//   for the inter-frame gap.
//
//   Build option: TX_PAD_EN -- when defined, short frames are zero-padded
//   up to MIN_WORDS payload words; when undefined the PAD state does not
//   exist and short frames go out unpadded.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_dat/s_valid/s_last/s_ready   upstream payload handshake
//   crc_dat/crc_en  CRC engine data/advance (combinational from state)
//   crc_rst         CRC engine reset, registered, active-high
//   crc_out         CRC engine result (already inverted/bit-reversed)
//   tx_dat/tx_en    registered line word and frame-content qualifier
//   tx_err          registered one-cycle abort strobe
//   busy            state != IDLE
//   frame_cnt       registered count of completed frames (wraps)
module mac_tx_framer #(
  parameter int unsigned PRE_WORDS = 4,
  parameter int unsigned MIN_WORDS = 30,
  parameter int unsigned MAX_WORDS = 757,
  parameter int unsigned IFG_WORDS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_dat,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] crc_dat,
  output logic        crc_en,
  output logic        crc_rst,
  input  logic [31:0] crc_out,
  output logic [15:0] tx_dat,
  output logic        tx_en,
  output logic        tx_err,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  // One counter serves as preamble index, payload word count and gap count;
  // it must reach MAX_WORDS+1 so the oversize word can be recognised.
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
`ifdef TX_PAD_EN
    PAD,
`endif
    FCS0,
    FCS1,
    IFG
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tx_dat_q, tx_dat_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_err_q, tx_err_d;
  logic          crc_rst_q, crc_rst_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_dat_d    = '0;
    tx_en_d     = 1'b0;
    tx_err_d    = 1'b0;
    crc_rst_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    s_ready     = 1'b0;
    crc_en      = 1'b0;
    crc_dat     = '0;
    unique case (state_q)
      IDLE: begin
        // Engine held in reset; the starting word is not consumed here.
        crc_rst_d = 1'b1;
        cnt_d     = '0;
        if (s_valid) state_d = PRE;
      end
      PRE: begin
        tx_en_d  = 1'b1;
        tx_dat_d = (cnt_q == CW'(PRE_WORDS - 1)) ? 16'hD555 : 16'h5555;
        if (cnt_q == CW'(PRE_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          crc_en  = 1'b1;
          crc_dat = s_dat;
          cnt_d   = cnt_q + 1'b1;
          if (!s_last && cnt_q == CW'(MAX_WORDS)) begin
            // Oversize: the word is swallowed and the frame aborted.
            tx_err_d = 1'b1;
            cnt_d    = '0;
            state_d  = IFG;
          end else begin
            tx_en_d  = 1'b1;
            tx_dat_d = s_dat;
            if (s_last) begin
`ifdef TX_PAD_EN
              state_d = (cnt_q < CW'(MIN_WORDS - 1)) ? PAD : FCS0;
`else
              state_d = FCS0;
`endif
            end
          end
        end else begin
          // Underrun: no FCS is sent, frame is not counted.
          tx_err_d = 1'b1;
          cnt_d    = '0;
          state_d  = IFG;
        end
      end
`ifdef TX_PAD_EN
      PAD: begin
        crc_en  = 1'b1;
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(MIN_WORDS - 1)) state_d = FCS0;
      end
`endif
      // crc_en stays low in both FCS states, so crc_out is frozen.
      FCS0: begin
        tx_en_d  = 1'b1;
        tx_dat_d = crc_out[31:16];
        state_d  = FCS1;
      end
      FCS1: begin
        tx_en_d     = 1'b1;
        tx_dat_d    = crc_out[15:0];
        frame_cnt_d = frame_cnt_q + 16'd1;
        cnt_d       = '0;
        state_d     = IFG;
      end
      IFG: begin
        crc_rst_d = 1'b1;
        if (cnt_q == CW'(IFG_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_dat_q    <= '0;
      tx_en_q     <= 1'b0;
      tx_err_q    <= 1'b0;
      crc_rst_q   <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_dat_q    <= tx_dat_d;
      tx_en_q     <= tx_en_d;
      tx_err_q    <= tx_err_d;
      crc_rst_q   <= crc_rst_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_dat    = tx_dat_q;
  assign tx_en     = tx_en_q;
  assign tx_err    = tx_err_q;
  assign crc_rst   = crc_rst_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: behavioural 16-bit CRC-32 engine on the crc_*
// ports, byte-wise software CRC-32 for expected FCS, table of frame vectors
// plus hand sequences for back-to-back frames and a mid-frame reset.
module tb_mac_tx_framer;
  localparam int PRE = 4;
  localparam int MIN = 30;
  localparam int MAX = 757;
`ifdef TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef logic [15:0] wq_t[$];
  typedef struct {
    int n; bit last; int drop; int seed; int len; int err; int inc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_dat;
  logic        s_valid, s_last, s_ready;
  logic [15:0] crc_dat;
  logic        crc_en, crc_rst;
  logic [31:0] crc_out;
  logic [15:0] tx_dat;
  logic        tx_en, tx_err, busy;
  logic [15:0] frame_cnt;

  mac_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .s_dat(s_dat), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .crc_dat(crc_dat), .crc_en(crc_en), .crc_rst(crc_rst),
    .crc_out(crc_out), .tx_dat(tx_dat), .tx_en(tx_en), .tx_err(tx_err),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // CRC engine: reflected CRC-32, low byte first, bit 0 first; reset only
  // through crc_rst so the framer's reset handling is exercised.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [15:0] d);
    logic [31:0] c;
    c = c_in;
    for (int j = 0; j < 16; j++) begin
      if (c[0] ^ d[j]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [31:0] eng_q;
  always @(posedge clk) begin
    if (crc_rst)     eng_q <= '1;
    else if (crc_en) eng_q <= crc_step(eng_q, crc_dat);
  end
  assign crc_out = ~eng_q;

  // Software reference: standard byte-wise CRC-32 over lo,hi bytes.
  function automatic logic [31:0] crc_model(input wq_t w);
    logic [31:0] c;
    logic [7:0]  by;
    c = '1;
    foreach (w[k]) begin
      for (int b = 0; b < 2; b++) begin
        by = (b == 0) ? w[k][7:0] : w[k][15:8];
        c  = c ^ {24'd0, by};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic logic [15:0] gen_word(input int seed, input int i);
    return 16'((seed * 40503) ^ (i * 945) ^ (i << 9) ^ 16'h00A5);
  endfunction

  wq_t st_dat;
  bit  st_last[$];
  wq_t cap, exp_q;
  int  gaps[$];
  int  nerr, rst_lo;
  int  ncmp = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({t, "_crc_en"}, 32'(crc_en), 32'd0);
    chk({t, "_crc_dat"}, 32'(crc_dat), 32'd0);
    chk({t, "_crc_rst"}, 32'(crc_rst), 32'd1);
    chk({t, "_tx_dat"}, 32'(tx_dat), 32'd0);
    chk({t, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({t, "_tx_err"}, 32'(tx_err), 32'd0);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic load(input int seed, input int n, input bit has_last);
    for (int i = 0; i < n; i++) begin
      st_dat.push_back(gen_word(seed, i));
      st_last.push_back(has_last && (i == n - 1));
    end
  endtask

  function automatic void add_exp(input int seed, input int k, input bit fcs);
    wq_t body;
    logic [31:0] f;
    for (int p = 0; p < PRE; p++) exp_q.push_back((p == PRE - 1) ? 16'hD555 : 16'h5555);
    for (int i = 0; i < k; i++) body.push_back(gen_word(seed, i));
    if (fcs && PAD) while (body.size() < MIN) body.push_back(16'h0000);
    foreach (body[j]) exp_q.push_back(body[j]);
    if (fcs) begin
      f = crc_model(body);
      exp_q.push_back(f[31:16]);
      exp_q.push_back(f[15:0]);
    end
  endfunction

  task automatic chk_content(input string name);
    int bad, lim;
    bad = -1;
    lim = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int k = 0; k < lim; k++)
      if (cap[k] !== exp_q[k]) begin bad = k; break; end
    if (bad < 0 && cap.size() != exp_q.size()) bad = lim;
    ncmp++;
    if (bad >= 0) begin
      nfail++;
      $display("FAIL %s: first bad word %0d got %h need %h (len %0d, need %0d)", name, bad,
               (bad < cap.size()) ? cap[bad] : 16'hxxxx,
               (bad < exp_q.size()) ? exp_q[bad] : 16'hxxxx, cap.size(), exp_q.size());
    end
  endtask

  // Streams st_dat into the DUT and captures every tx_en word. s_valid is
  // withdrawn permanently once drop_at words are accepted; rst_at pulses
  // rst_n low for one cycle once rst_at words are accepted.
  task automatic run(input string name, input int drop_at, input int rst_at, input int budget);
    int  i, gap;
    bit  acc, started, done, did_rst;
    i = 0; gap = 0; acc = 0; started = 0; done = 0; did_rst = 0;
    cap.delete(); gaps.delete(); nerr = 0; rst_lo = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (tx_en) begin
        if (started && gap > 0) gaps.push_back(gap);
        cap.push_back(tx_dat);
        gap = 0; started = 1;
      end else begin
        gap++;
        if (!crc_rst && !tx_err) rst_lo++;
      end
      if (tx_err) nerr++;
      if (acc) i++;
      if (rst_at >= 0 && !did_rst && i == rst_at) begin
        did_rst = 1;
        #2 rst_n = 1'b0;
        #1 chk_reset({name, "_async"});
        i = st_dat.size(); acc = 0;
        s_valid = 1'b0; s_dat = '0; s_last = 1'b0;
        cap.delete();
        continue;
      end
      if (did_rst && !rst_n) rst_n = 1'b1;
      if ((i >= st_dat.size() || i == drop_at) && !busy && cyc > 0) begin
        s_valid = 1'b0; s_dat = '0; s_last = 1'b0;
        done = 1;
        break;
      end
      if (i < st_dat.size() && i != drop_at) begin
        s_valid = 1'b1; s_dat = st_dat[i]; s_last = st_last[i];
      end else begin
        s_valid = 1'b0; s_dat = '0; s_last = 1'b0;
      end
      acc = s_valid && s_ready;
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL %s_timeout: no return to idle within %0d cycles", name, budget);
      s_valid = 1'b0; s_dat = '0; s_last = 1'b0;
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic [15:0] fc0, dfc;
    int k;
    tbl[0] = '{n: 32,  last: 1, drop: -1, seed: 1, len: 38,             err: 0, inc: 1};
    tbl[1] = '{n: 10,  last: 1, drop: -1, seed: 2, len: PAD ? 36 : 16,  err: 0, inc: 1};
    tbl[2] = '{n: 30,  last: 1, drop: -1, seed: 3, len: 36,             err: 0, inc: 1};
    tbl[3] = '{n: 29,  last: 1, drop: -1, seed: 4, len: PAD ? 36 : 35,  err: 0, inc: 1};
    tbl[4] = '{n: 1,   last: 1, drop: -1, seed: 5, len: PAD ? 36 : 7,   err: 0, inc: 1};
    tbl[5] = '{n: 40,  last: 1, drop: 12, seed: 6, len: 16,             err: 1, inc: 0};
    tbl[6] = '{n: 40,  last: 1, drop: 1,  seed: 7, len: 5,              err: 1, inc: 0};
    tbl[7] = '{n: 758, last: 0, drop: -1, seed: 8, len: 761,            err: 1, inc: 0};
    tbl[8] = '{n: 757, last: 1, drop: -1, seed: 9, len: 763,            err: 0, inc: 1};

    rst_n = 1'b0; s_valid = 1'b0; s_dat = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    foreach (tbl[v]) begin
      st_dat.delete(); st_last.delete(); exp_q.delete();
      load(tbl[v].seed, tbl[v].n, tbl[v].last);
      k = (tbl[v].err != 0) ? ((tbl[v].drop >= 0) ? tbl[v].drop : MAX) : tbl[v].n;
      add_exp(tbl[v].seed, k, tbl[v].err == 0);
      fc0 = frame_cnt;
      run($sformatf("v%0d", v), tbl[v].drop, -1, tbl[v].n + 200);
      dfc = frame_cnt - fc0;
      chk($sformatf("v%0d_len", v), 32'(cap.size()), 32'(tbl[v].len));
      chk_content($sformatf("v%0d_words", v));
      chk($sformatf("v%0d_tx_err", v), 32'(nerr), 32'(tbl[v].err));
      chk($sformatf("v%0d_frame_cnt", v), 32'(dfc), 32'(tbl[v].inc));
    end

    // Back-to-back frames with s_valid never dropping between them.
    st_dat.delete(); st_last.delete(); exp_q.delete();
    load(11, 20, 1); load(12, 33, 1);
    add_exp(11, 20, 1); add_exp(12, 33, 1);
    fc0 = frame_cnt;
    run("b2b", -1, -1, 300);
    dfc = frame_cnt - fc0;
    chk_content("b2b_words");
    chk("b2b_gaps", 32'(gaps.size()), 32'd1);
    if (gaps.size() == 1) chk("b2b_gap_ge6", 32'(gaps[0] >= 6), 32'd1);
    chk("b2b_crc_rst_gap", 32'(rst_lo), 32'd0);
    chk("b2b_tx_err", 32'(nerr), 32'd0);
    chk("b2b_frame_cnt", 32'(dfc), 32'd2);

    // One-cycle reset in the middle of DATA, then a clean frame.
    st_dat.delete(); st_last.delete(); exp_q.delete();
    load(13, 40, 1);
    run("midrst", -1, 10, 200);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    st_dat.delete(); st_last.delete(); exp_q.delete();
    load(14, 16, 1);
    add_exp(14, 16, 1);
    run("post", -1, -1, 200);
    chk_content("post_words");
    chk("post_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
